// File: rtl/sprite_blitter.sv
// sprite_blitter: streams a SIZE x SIZE 1-bit sprite (rotated, coloured) to a TFT byte sender.
// A move first erases only the vacated strip (or the whole old box), then redraws the sprite.
module sprite_blitter #(
   parameter int SIZE   = 22,
   parameter int BPP    = 3,
   parameter int FRAMES = 4,
   localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1,
   localparam int AW    = (FRAMES*SIZE*SIZE > 1) ? $clog2(FRAMES*SIZE*SIZE) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               draw,
   input  logic [8:0]         x,
   input  logic [8:0]         y,
   input  logic [1:0]         direction,
   input  logic [FW-1:0]      frame,
   input  logic [8*BPP-1:0]   fg_color,
   input  logic [8*BPP-1:0]   bg_color,
   output logic [AW-1:0]      rom_addr,
   input  logic               rom_data,
   output logic               busy,
   input  logic               tft_busy,
   output logic               tft_transmit,
   output logic               tft_dc,
   output logic [7:0]         tft_data
);

   localparam logic [8:0] SZ9  = 9'(SIZE);
   localparam logic [8:0] SZM1 = 9'(SIZE - 1);

   typedef enum logic [2:0] {S_IDLE, S_ERASE_WIN, S_ERASE_PIX, S_DRAW_WIN, S_DRAW_PIX} state_t;

   state_t             state_q;
   logic               busy_q, tx_q, dc_q, vld_q, bit_q;
   logic [7:0]         data_q;
   logic [AW-1:0]      rom_addr_q;
   logic [8:0]         xo_q, yo_q, xn_q, yn_q;
   logic [8:0]         xs_q, xe_q, ys_q, ye_q, px_q, py_q;
   logic [1:0]         dir_q, ph_q, byte_q;
   logic [FW-1:0]      frame_q;
   logic [8*BPP-1:0]   fg_q, bg_q;
   logic [3:0]         idx_q;

   logic               has_erase_d;
   logic [8:0]         exs_d, exe_d, eys_d, eye_d;
   logic [AW-1:0]      addr_d;
   logic [8:0]         win_byte_d;
   logic [7:0]         pix_byte_d;
   logic               can_send;

   assign busy         = busy_q;
   assign tft_transmit = tx_q;
   assign tft_dc       = dc_q;
   assign tft_data     = data_q;
   assign rom_addr     = rom_addr_q;
   assign can_send     = ~tft_busy & ~tx_q;

   // Erase rectangle: vacated strip for a short axis-aligned move, else the whole old box
   always_comb begin
      logic [8:0] dx, dy, dxn, dyn;
      dx  = x - xo_q;
      dy  = y - yo_q;
      dxn = xo_q - x;
      dyn = yo_q - y;
      has_erase_d = 1'b1;
      exs_d = xo_q;
      exe_d = xo_q + SZM1;
      eys_d = yo_q;
      eye_d = yo_q + SZM1;
      if (!vld_q || (dx == 9'd0 && dy == 9'd0)) has_erase_d = 1'b0;
      else if (dy == 9'd0 && dx  < SZ9) exe_d = x - 9'd1;
      else if (dy == 9'd0 && dxn < SZ9) exs_d = x + SZ9;
      else if (dx == 9'd0 && dy  < SZ9) eye_d = y - 9'd1;
      else if (dx == 9'd0 && dyn < SZ9) eys_d = y + SZ9;
   end

   // Bitmap address of the current window pixel after rotation
   always_comb begin
      logic [8:0] u, v;
      case (dir_q)
         2'd0:    begin u = px_q;        v = py_q;        end
         2'd1:    begin u = py_q;        v = SZM1 - px_q; end
         2'd2:    begin u = SZM1 - px_q; v = SZM1 - py_q; end
         default: begin u = SZM1 - py_q; v = px_q;        end
      endcase
      addr_d = AW'(frame_q) * AW'(SIZE*SIZE) + AW'(v) * AW'(SIZE) + AW'(u);
   end

   // Window-setup byte for the current index, {dc, byte}
   always_comb begin
      win_byte_d = {1'b0, 8'h2C};
      case (idx_q)
         4'd0:    win_byte_d = {1'b0, 8'h2A};
         4'd1:    win_byte_d = {1'b1, 7'd0, xs_q[8]};
         4'd2:    win_byte_d = {1'b1, xs_q[7:0]};
         4'd3:    win_byte_d = {1'b1, 7'd0, xe_q[8]};
         4'd4:    win_byte_d = {1'b1, xe_q[7:0]};
         4'd5:    win_byte_d = {1'b0, 8'h2B};
         4'd6:    win_byte_d = {1'b1, 7'd0, ys_q[8]};
         4'd7:    win_byte_d = {1'b1, ys_q[7:0]};
         4'd8:    win_byte_d = {1'b1, 7'd0, ye_q[8]};
         4'd9:    win_byte_d = {1'b1, ye_q[7:0]};
         default: win_byte_d = {1'b0, 8'h2C};
      endcase
   end

   // Pixel colour byte, most significant byte first; erase always uses bg
   always_comb begin
      logic [8*BPP-1:0] col, sh;
      col = (state_q == S_DRAW_PIX && bit_q) ? fg_q : bg_q;
      sh  = col << {byte_q, 3'b000};
      pix_byte_d = sh[8*BPP-1 -: 8];
   end

   // Main FSM: window setup, per-pixel ROM fetch (addr, wait, capture) then BPP byte strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         tx_q       <= 1'b0;
         dc_q       <= 1'b0;
         data_q     <= 8'd0;
         rom_addr_q <= '0;
         vld_q      <= 1'b0;
      end else begin
         tx_q <= 1'b0;
         if (enable) begin
            case (state_q)
               S_IDLE: begin
                  busy_q <= 1'b0;
                  if (draw && !busy_q) begin
                     busy_q  <= 1'b1;
                     xn_q    <= x;
                     yn_q    <= y;
                     dir_q   <= direction;
                     frame_q <= (int'(frame) >= FRAMES) ? FW'(FRAMES - 1) : frame;
                     fg_q    <= fg_color;
                     bg_q    <= bg_color;
                     idx_q   <= 4'd0;
                     px_q    <= 9'd0;
                     py_q    <= 9'd0;
                     byte_q  <= 2'd0;
                     if (has_erase_d) begin
                        xs_q <= exs_d; xe_q <= exe_d; ys_q <= eys_d; ye_q <= eye_d;
                        state_q <= S_ERASE_WIN;
                     end else begin
                        xs_q <= x; xe_q <= x + SZM1; ys_q <= y; ye_q <= y + SZM1;
                        state_q <= S_DRAW_WIN;
                     end
                  end
               end
               S_ERASE_WIN, S_DRAW_WIN: begin
                  if (can_send) begin
                     tx_q <= 1'b1;
                     {dc_q, data_q} <= win_byte_d;
                     if (idx_q == 4'd10) begin
                        idx_q   <= 4'd0;
                        state_q <= (state_q == S_ERASE_WIN) ? S_ERASE_PIX : S_DRAW_PIX;
                        ph_q    <= (state_q == S_ERASE_WIN) ? 2'd3 : 2'd0;
                     end else begin
                        idx_q <= idx_q + 4'd1;
                     end
                  end
               end
               S_ERASE_PIX, S_DRAW_PIX: begin
                  if (ph_q == 2'd0) begin
                     rom_addr_q <= addr_d;
                     ph_q <= 2'd1;
                  end else if (ph_q == 2'd1) begin
                     ph_q <= 2'd2;
                  end else if (ph_q == 2'd2) begin
                     bit_q <= rom_data;
                     ph_q  <= 2'd3;
                  end else if (can_send) begin
                     tx_q   <= 1'b1;
                     dc_q   <= 1'b1;
                     data_q <= pix_byte_d;
                     if (byte_q == 2'(BPP - 1)) begin
                        byte_q <= 2'd0;
                        ph_q   <= (state_q == S_DRAW_PIX) ? 2'd0 : 2'd3;
                        if (px_q == xe_q - xs_q) begin
                           px_q <= 9'd0;
                           if (py_q == ye_q - ys_q) begin
                              py_q <= 9'd0;
                              if (state_q == S_ERASE_PIX) begin
                                 xs_q <= xn_q; xe_q <= xn_q + SZM1;
                                 ys_q <= yn_q; ye_q <= yn_q + SZM1;
                                 state_q <= S_DRAW_WIN;
                              end else begin
                                 xo_q    <= xn_q;
                                 yo_q    <= yn_q;
                                 vld_q   <= 1'b1;
                                 state_q <= S_IDLE;
                              end
                           end else begin
                              py_q <= py_q + 9'd1;
                           end
                        end else begin
                           px_q <= px_q + 9'd1;
                        end
                     end else begin
                        byte_q <= byte_q + 2'd1;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized bench for sprite_blitter against a rectangle/pixel reference model.
module tb_sprite_blitter;

   localparam int SIZE = 22, BPP = 3, FRAMES = 4;
   localparam int NPX  = SIZE * SIZE;

   logic        clk = 1'b0;
   logic        rst, enable, draw, rom_data, busy, tft_busy, tft_transmit, tft_dc;
   logic [8:0]  x, y;
   logic [1:0]  direction, frame;
   logic [23:0] fg_color, bg_color;
   logic [10:0] rom_addr;
   logic [7:0]  tft_data;

   bit          rom_mem [2048];
   logic [8:0]  cap[$];
   logic [8:0]  exp_q[$];
   logic [7:0]  wexp [11];
   int          cyc = 0, last_strobe = 0, dbl = 0;
   logic        prev_tx = 1'b0;
   int          vec = 0, miscmp = 0;
   bit          tmo;
   int          fall_lat;
   bit          m_vld = 1'b0;
   int          m_xo = 0, m_yo = 0;

   sprite_blitter #(.SIZE(SIZE), .BPP(BPP), .FRAMES(FRAMES)) dut (
      .clk(clk), .rst(rst), .enable(enable), .draw(draw), .x(x), .y(y),
      .direction(direction), .frame(frame), .fg_color(fg_color), .bg_color(bg_color),
      .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .tft_busy(tft_busy),
      .tft_transmit(tft_transmit), .tft_dc(tft_dc), .tft_data(tft_data));

   always #5 clk = ~clk;

   // Synchronous bitmap ROM: data for an address appears the cycle after it is presented
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   always @(posedge clk) cyc <= cyc + 1;

   // Byte monitor on the falling edge
   always @(negedge clk) begin
      if (tft_transmit) begin
         cap.push_back({tft_dc, tft_data});
         last_strobe <= cyc;
         if (prev_tx) dbl <= dbl + 1;
      end
      prev_tx <= tft_transmit;
   end

   initial begin
      #1200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   task automatic add_win(input logic [8:0] xs, xe, ys, ye);
      exp_q.push_back(9'h02A);
      exp_q.push_back({1'b1, 7'd0, xs[8]}); exp_q.push_back({1'b1, xs[7:0]});
      exp_q.push_back({1'b1, 7'd0, xe[8]}); exp_q.push_back({1'b1, xe[7:0]});
      exp_q.push_back(9'h02B);
      exp_q.push_back({1'b1, 7'd0, ys[8]}); exp_q.push_back({1'b1, ys[7:0]});
      exp_q.push_back({1'b1, 7'd0, ye[8]}); exp_q.push_back({1'b1, ye[7:0]});
      exp_q.push_back(9'h02C);
   endtask

   task automatic add_px(input logic [23:0] c);
      exp_q.push_back({1'b1, c[23:16]});
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
   endtask

   task automatic build(input logic [8:0] nx, ny, input logic [1:0] d, f, input logic [23:0] fg, bg);
      int dx, dy, ex0, ex1, ey0, ey1, w, h, u, v;
      bit has;
      exp_q.delete();
      dx = (int'(nx) - m_xo) & 511;
      dy = (int'(ny) - m_yo) & 511;
      has = 1'b1;
      ex0 = m_xo; ex1 = m_xo + SIZE - 1; ey0 = m_yo; ey1 = m_yo + SIZE - 1;
      if (!m_vld || (dx == 0 && dy == 0)) has = 1'b0;
      else if (dy == 0 && dx < SIZE)       ex1 = int'(nx) - 1;
      else if (dy == 0 && 512 - dx < SIZE) ex0 = int'(nx) + SIZE;
      else if (dx == 0 && dy < SIZE)       ey1 = int'(ny) - 1;
      else if (dx == 0 && 512 - dy < SIZE) ey0 = int'(ny) + SIZE;
      if (has) begin
         add_win(9'(ex0), 9'(ex1), 9'(ey0), 9'(ey1));
         w = ((ex1 - ex0) & 511) + 1;
         h = ((ey1 - ey0) & 511) + 1;
         for (int i = 0; i < w * h; i++) add_px(bg);
      end
      add_win(nx, 9'(int'(nx) + SIZE - 1), ny, 9'(int'(ny) + SIZE - 1));
      for (int py = 0; py < SIZE; py++)
         for (int px = 0; px < SIZE; px++) begin
            case (d)
               2'd0:    begin u = px;            v = py;            end
               2'd1:    begin u = py;            v = SIZE - 1 - px; end
               2'd2:    begin u = SIZE - 1 - px; v = SIZE - 1 - py; end
               default: begin u = SIZE - 1 - py; v = px;            end
            endcase
            add_px(rom_mem[int'(f) * NPX + v * SIZE + u] ? fg : bg);
         end
   endtask

   function automatic int first_diff();
      int n;
      n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) return i;
      if (cap.size() != exp_q.size()) return n;
      return -1;
   endfunction

   function automatic bit win_match(input int base);
      for (int i = 0; i < 11; i++) begin
         if (base + i >= cap.size()) return 1'b0;
         if (cap[base + i][7:0] !== wexp[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Drives one draw request, holds junk on the inputs while busy, collects bytes
   task automatic run_draw(input logic [8:0] nx, ny, input logic [1:0] d, f,
                           input logic [23:0] fg, bg, input bit rnd);
      int n;
      build(nx, ny, d, f, fg, bg);
      @(negedge clk);
      cap.delete(); dbl = 0; tmo = 1'b0; fall_lat = -1;
      x = nx; y = ny; direction = d; frame = f; fg_color = fg; bg_color = bg; draw = 1'b1;
      n = 0;
      while (!busy && n < 200) begin
         @(negedge clk);
         if (rnd) enable = ($urandom_range(0, 3) != 0);
         n++;
      end
      if (!busy) begin
         tmo = 1'b1; draw = 1'b0; enable = 1'b1;
         return;
      end
      n = 0;
      while (busy && n < 40000) begin
         x = 9'($urandom); y = 9'($urandom); direction = 2'($urandom); frame = 2'($urandom);
         fg_color = 24'($urandom); bg_color = 24'($urandom); draw = 1'($urandom_range(0, 1));
         if (rnd) begin
            enable   = ($urandom_range(0, 4) != 0);
            tft_busy = ($urandom_range(0, 5) < 2);
         end
         @(negedge clk);
         n++;
      end
      draw = 1'b0; enable = 1'b1; tft_busy = 1'b0;
      if (busy) tmo = 1'b1;
      else begin
         fall_lat = cyc - last_strobe;
         m_vld = 1'b1; m_xo = int'(nx); m_yo = int'(ny);
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL reset.busy got %b want 0", busy); end
      vec++; if (tft_transmit !== 1'b0) begin miscmp++; $display("FAIL reset.tft_transmit got %b want 0", tft_transmit); end
      vec++; if (tft_dc !== 1'b0) begin miscmp++; $display("FAIL reset.tft_dc got %b want 0", tft_dc); end
      vec++; if (tft_data !== 8'h00) begin miscmp++; $display("FAIL reset.tft_data got %h want 00", tft_data); end
      vec++; if (rom_addr !== 11'd0) begin miscmp++; $display("FAIL reset.rom_addr got %0d want 0", rom_addr); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_first_draw();
      int fd;
      for (int i = 0; i < FRAMES * NPX; i++) rom_mem[i] = 1'($urandom);
      run_draw(9'd5, 9'd5, 2'd0, 2'd1, 24'($urandom), 24'($urandom), 1'b0);
      vec++; if (tmo !== 1'b0) begin miscmp++; $display("FAIL first.timeout got %b want 0", tmo); end
      wexp = '{8'h2A, 8'h00, 8'h05, 8'h00, 8'h1A, 8'h2B, 8'h00, 8'h05, 8'h00, 8'h1A, 8'h2C};
      vec++; if (!win_match(0)) begin miscmp++; $display("FAIL first.window got %h %h %h %h %h want 2A 00 05 00 1A", cap[0], cap[1], cap[2], cap[3], cap[4]); end
      vec++; if (cap.size() !== 11 + NPX * BPP) begin miscmp++; $display("FAIL first.count got %0d want %0d", cap.size(), 11 + NPX * BPP); end
      fd = first_diff();
      vec++; if (fd != -1) begin miscmp++; $display("FAIL first.seq at %0d got %h want %h (sizes %0d/%0d)", fd, (fd < cap.size()) ? cap[fd] : 9'h1FF, (fd < exp_q.size()) ? exp_q[fd] : 9'h1FF, cap.size(), exp_q.size()); end
      vec++; if (fall_lat !== 1) begin miscmp++; $display("FAIL first.busy_fall got %0d want 1", fall_lat); end
      vec++; if (dbl !== 0) begin miscmp++; $display("FAIL first.double_strobe got %0d want 0", dbl); end
   endtask

   task automatic test_move_right();
      int fd;
      run_draw(9'd7, 9'd5, 2'd0, 2'd1, 24'($urandom), 24'($urandom), 1'b0);
      vec++; if (tmo !== 1'b0) begin miscmp++; $display("FAIL right.timeout got %b want 0", tmo); end
      wexp = '{8'h2A, 8'h00, 8'h05, 8'h00, 8'h06, 8'h2B, 8'h00, 8'h05, 8'h00, 8'h1A, 8'h2C};
      vec++; if (!win_match(0)) begin miscmp++; $display("FAIL right.erase_window got %h %h %h %h %h want 2A 00 05 00 06", cap[0], cap[1], cap[2], cap[3], cap[4]); end
      wexp = '{8'h2A, 8'h00, 8'h07, 8'h00, 8'h1C, 8'h2B, 8'h00, 8'h05, 8'h00, 8'h1A, 8'h2C};
      vec++; if (!win_match(11 + 44 * BPP)) begin miscmp++; $display("FAIL right.draw_window not found at byte %0d (size %0d)", 11 + 44 * BPP, cap.size()); end
      fd = first_diff();
      vec++; if (fd != -1) begin miscmp++; $display("FAIL right.seq at %0d got %h want %h (sizes %0d/%0d)", fd, (fd < cap.size()) ? cap[fd] : 9'h1FF, (fd < exp_q.size()) ? exp_q[fd] : 9'h1FF, cap.size(), exp_q.size()); end
   endtask

   task automatic test_jump();
      int fd;
      run_draw(9'd40, 9'd40, 2'd1, 2'd3, 24'($urandom), 24'($urandom), 1'b0);
      vec++; if (tmo !== 1'b0) begin miscmp++; $display("FAIL jump.timeout got %b want 0", tmo); end
      wexp = '{8'h2A, 8'h00, 8'h07, 8'h00, 8'h1C, 8'h2B, 8'h00, 8'h05, 8'h00, 8'h1A, 8'h2C};
      vec++; if (!win_match(0)) begin miscmp++; $display("FAIL jump.erase_window got %h %h %h %h %h want 2A 00 07 00 1C", cap[0], cap[1], cap[2], cap[3], cap[4]); end
      vec++; if (cap.size() !== 2 * (11 + NPX * BPP)) begin miscmp++; $display("FAIL jump.count got %0d want %0d", cap.size(), 2 * (11 + NPX * BPP)); end
      fd = first_diff();
      vec++; if (fd != -1) begin miscmp++; $display("FAIL jump.seq at %0d got %h want %h (sizes %0d/%0d)", fd, (fd < cap.size()) ? cap[fd] : 9'h1FF, (fd < exp_q.size()) ? exp_q[fd] : 9'h1FF, cap.size(), exp_q.size()); end
   endtask

   task automatic test_left_and_vertical();
      int fd;
      run_draw(9'd38, 9'd40, 2'd2, 2'd0, 24'($urandom), 24'($urandom), 1'b0);
      wexp = '{8'h2A, 8'h00, 8'h3C, 8'h00, 8'h3D, 8'h2B, 8'h00, 8'h28, 8'h00, 8'h3D, 8'h2C};
      vec++; if (tmo !== 1'b0 || !win_match(0)) begin miscmp++; $display("FAIL left.erase_window tmo %b got %h %h %h %h %h want 2A 00 3C 00 3D", tmo, cap[0], cap[1], cap[2], cap[3], cap[4]); end
      fd = first_diff();
      vec++; if (fd != -1) begin miscmp++; $display("FAIL left.seq at %0d got %h want %h (sizes %0d/%0d)", fd, (fd < cap.size()) ? cap[fd] : 9'h1FF, (fd < exp_q.size()) ? exp_q[fd] : 9'h1FF, cap.size(), exp_q.size()); end
      run_draw(9'd38, 9'd43, 2'd3, 2'd2, 24'($urandom), 24'($urandom), 1'b0);
      wexp = '{8'h2A, 8'h00, 8'h26, 8'h00, 8'h3B, 8'h2B, 8'h00, 8'h28, 8'h00, 8'h2A, 8'h2C};
      vec++; if (tmo !== 1'b0 || !win_match(0)) begin miscmp++; $display("FAIL down.erase_window tmo %b got %h %h %h %h %h %h %h %h %h want ... 28 00 2A", tmo, cap[0], cap[1], cap[2], cap[3], cap[4], cap[6], cap[7], cap[8], cap[9]); end
      fd = first_diff();
      vec++; if (fd != -1) begin miscmp++; $display("FAIL down.seq at %0d got %h want %h (sizes %0d/%0d)", fd, (fd < cap.size()) ? cap[fd] : 9'h1FF, (fd < exp_q.size()) ? exp_q[fd] : 9'h1FF, cap.size(), exp_q.size()); end
   endtask

   task automatic test_rotation();
      int fd, cnt, pos, epos;
      int exp_pos [4];
      logic [23:0] fg, bg;
      exp_pos = '{0, SIZE - 1, (SIZE - 1) * SIZE + SIZE - 1, (SIZE - 1) * SIZE};
      fg = 24'hF01234;
      bg = 24'h0F5678;
      for (int d = 0; d < 4; d++) begin
         for (int i = 0; i < 2048; i++) rom_mem[i] = 1'b0;
         rom_mem[2 * NPX] = 1'b1;
         run_draw(9'd38, 9'd43, 2'(d), 2'd2, fg, bg, 1'b0);
         cnt = 0; pos = -1;
         if (cap.size() >= 11 + NPX * BPP)
            for (int p = 0; p < NPX; p++)
               if ({cap[11 + 3 * p][7:0], cap[12 + 3 * p][7:0], cap[13 + 3 * p][7:0]} === fg) begin
                  cnt++; pos = p;
               end
         epos = exp_pos[d];
         vec++; if (tmo !== 1'b0 || cnt !== 1 || pos !== epos) begin miscmp++; $display("FAIL rot%0d.fg_pixel tmo %b count %0d at %0d want count 1 at %0d", d, tmo, cnt, pos, epos); end
         fd = first_diff();
         vec++; if (fd != -1) begin miscmp++; $display("FAIL rot%0d.seq at %0d got %h want %h (sizes %0d/%0d)", d, fd, (fd < cap.size()) ? cap[fd] : 9'h1FF, (fd < exp_q.size()) ? exp_q[fd] : 9'h1FF, cap.size(), exp_q.size()); end
      end
   endtask

   task automatic test_busy_enable();
      int fd;
      for (int i = 0; i < FRAMES * NPX; i++) rom_mem[i] = 1'($urandom);
      run_draw(9'd40, 9'd43, 2'($urandom), 2'd3, 24'($urandom), 24'($urandom), 1'b1);
      vec++; if (tmo !== 1'b0) begin miscmp++; $display("FAIL stall.timeout got %b want 0", tmo); end
      fd = first_diff();
      vec++; if (fd != -1) begin miscmp++; $display("FAIL stall.seq at %0d got %h want %h (sizes %0d/%0d)", fd, (fd < cap.size()) ? cap[fd] : 9'h1FF, (fd < exp_q.size()) ? exp_q[fd] : 9'h1FF, cap.size(), exp_q.size()); end
      vec++; if (dbl !== 0) begin miscmp++; $display("FAIL stall.double_strobe got %0d want 0", dbl); end
   endtask

   task automatic test_reset_mid();
      int n, fd;
      @(negedge clk);
      x = 9'd42; y = 9'd43; direction = 2'd0; frame = 2'd0; draw = 1'b1;
      cap.delete();
      n = 0;
      while (cap.size() < 20 && n < 2000) begin @(negedge clk); draw = 1'b0; n++; end
      vec++; if (cap.size() < 20) begin miscmp++; $display("FAIL rstmid.reach_erase got %0d bytes want 20", cap.size()); end
      rst = 1'b1;
      @(negedge clk);
      vec++; if (busy !== 1'b0 || tft_transmit !== 1'b0) begin miscmp++; $display("FAIL rstmid.outputs busy %b tx %b want 0 0", busy, tft_transmit); end
      rst = 1'b0;
      m_vld = 1'b0;
      run_draw(9'd250, 9'd300, 2'd1, 2'd1, 24'($urandom), 24'($urandom), 1'b0);
      wexp = '{8'h2A, 8'h00, 8'hFA, 8'h01, 8'h0F, 8'h2B, 8'h01, 8'h2C, 8'h01, 8'h41, 8'h2C};
      vec++; if (tmo !== 1'b0 || !win_match(0)) begin miscmp++; $display("FAIL rstmid.no_erase_window tmo %b got %h %h %h %h %h want 2A 00 FA 01 0F", tmo, cap[0], cap[1], cap[2], cap[3], cap[4]); end
      fd = first_diff();
      vec++; if (fd != -1) begin miscmp++; $display("FAIL rstmid.seq at %0d got %h want %h (sizes %0d/%0d)", fd, (fd < cap.size()) ? cap[fd] : 9'h1FF, (fd < exp_q.size()) ? exp_q[fd] : 9'h1FF, cap.size(), exp_q.size()); end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; draw = 1'b0; x = '0; y = '0; direction = '0; frame = '0;
      fg_color = '0; bg_color = '0; tft_busy = 1'b0;
      test_reset();
      test_first_draw();
      test_move_right();
      test_jump();
      test_left_and_vertical();
      test_rotation();
      test_busy_enable();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
